// File: rtl/microzed_fmc_led_axil_slave.sv
// AXI4-Lite slave: four 32-bit R/W registers driving the FMC LED pins.
// Optional hardware blink engine enabled by defining LED_BLINK_EN.
module microzed_fmc_led_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_LEDS         = 8
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_NUM_LEDS-1:0]           led_o
);
  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;

  wr_state_t                          wr_state;
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic [1:0]                         wr_idx, rd_idx;
  logic                               wr_fire, rd_fire;

  assign wr_idx  = s00_axi_awaddr[3:2];
  assign rd_idx  = s00_axi_araddr[3:2];
  // awready/wready are high only during WR_ACCEPT, so the handshake completes there
  assign wr_fire = (wr_state == WR_ACCEPT);
  assign rd_fire = s00_axi_arready && s00_axi_arvalid;

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;

  logic unused_in;
  assign unused_in = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state        <= WR_IDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
          s00_axi_awready <= 1'b1;
          s00_axi_wready  <= 1'b1;
          wr_state        <= WR_ACCEPT;
        end
        WR_ACCEPT: begin
          s00_axi_awready <= 1'b0;
          s00_axi_wready  <= 1'b0;
          s00_axi_bvalid  <= 1'b1;
          wr_state        <= WR_RESP;
        end
        WR_RESP: if (s00_axi_bready) begin
          s00_axi_bvalid <= 1'b0;
          wr_state       <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      regs <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NBYTES; b++)
        if (s00_axi_wstrb[b]) regs[wr_idx][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
    end
  end

  // rdata samples regs before this edge's write lands, so a colliding read sees the old value
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= 1'b0;
      if (s00_axi_rvalid && s00_axi_rready) s00_axi_rvalid <= 1'b0;
      if (rd_fire) begin
        s00_axi_rdata  <= regs[rd_idx];
        s00_axi_rvalid <= 1'b1;
      end else if (s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready) begin
        s00_axi_arready <= 1'b1;
      end
    end
  end

`ifdef LED_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_phase;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      led_o       <= '0;
    end else begin
      if (!regs[1][0] || regs[2] == '0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (wr_fire && wr_idx == 2'd2) begin
        blink_cnt <= '0;
      end else if (blink_cnt == regs[2]) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
      led_o <= regs[0][C_NUM_LEDS-1:0] & {C_NUM_LEDS{blink_phase}};
    end
  end
`else
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) led_o <= '0;
    else                  led_o <= regs[0][C_NUM_LEDS-1:0];
  end
`endif

endmodule

// File: tb/tb_microzed_fmc_led_axil_slave.sv
// Directed bench for microzed_fmc_led_axil_slave; blink checks build only with LED_BLINK_EN.
module tb_microzed_fmc_led_axil_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  led;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  microzed_fmc_led_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .led_o(led)
  );

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL wr_accept_timeout addr=%h", a); end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20 || bresp !== 2'b00) begin
      bad++; $display("FAIL wr_bresp addr=%h got=%b want=00 waited=%0d", a, bresp, n);
    end
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL rd_arready_timeout addr=%h", a); end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    d = rdata;
    total++;
    if (n >= 20 || rresp !== 2'b00) begin
      bad++; $display("FAIL rd_rresp addr=%h got=%b want=00 waited=%0d", a, rresp, n);
    end
    @(negedge clk);
    rready = 0;
  endtask

  task automatic check_reg(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    total++;
    if (d !== exp) begin bad++; $display("FAIL %s got=%h want=%h", nm, d, exp); end
  endtask

  task automatic test_reset();
    rst_n = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || led !== 8'h00 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_outputs hs=%b led=%h rdata=%h want all 0",
                      {awready, wready, bvalid, arready, rvalid}, led, rdata);
    end
    rst_n = 1;
    for (int i = 0; i < 4; i++) check_reg("reset_reg", 4'(i * 4), 32'h0);
  endtask

  task automatic test_basic();
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    check_reg("rd_reg0", 4'h0, 32'h1);
    check_reg("rd_reg1", 4'h4, 32'h2);
    check_reg("rd_reg2", 4'h8, 32'h3);
    check_reg("rd_reg3", 4'hC, 32'h4);
    check_reg("addr_lsb_ignored", 4'hB, 32'h3);
    total++;
    if (led !== 8'h01) begin bad++; $display("FAIL led_static got=%h want=01", led); end
  endtask

  task automatic test_strobe();
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'hC, 32'h1234_5678, 4'b0101);
    check_reg("wstrb_0101", 4'hC, 32'hFF34_FF78);
    axi_write(4'hE, 32'hAABB_CCDD, 4'b1000);
    check_reg("wstrb_1000", 4'hC, 32'hAA34_FF78);
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h11; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    awaddr = 4'h4; wdata = 32'h22; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d bvalid=%b awready=%b wready=%b want 1/0/0",
                        i, bvalid, awready, wready);
      end
      @(negedge clk);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL bp_release bvalid=%b want=0", bvalid); end
    axi_write(4'h4, 32'h22, 4'hF);
    check_reg("bp_first_write", 4'h0, 32'h11);
    check_reg("bp_second_write", 4'h4, 32'h22);
  endtask

  task automatic test_aw_first();
    int n;
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        bad++; $display("FAIL aw_first_wait cyc=%0d awready=%b wready=%b want 0", i, awready, wready);
      end
    end
    wvalid = 1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      bad++; $display("FAIL aw_first_pulse awready=%b wready=%b want 1", awready, wready);
    end
    @(negedge clk);
    total++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) begin
      bad++; $display("FAIL aw_first_single awready=%b wready=%b bvalid=%b want 0/0/1",
                      awready, wready, bvalid);
    end
    awvalid = 0; wvalid = 0;
    n = 0;
    while (bvalid && n < 5) begin @(negedge clk); n++; end
    check_reg("aw_first_data", 4'h8, 32'h77);
  endtask

  task automatic test_read_timing();
    logic [31:0] d0;
    @(negedge clk);
    araddr = 4'h8; arvalid = 1; rready = 0;
    @(negedge clk);
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_lat1 arready=%b rvalid=%b want 1/0", arready, rvalid);
    end
    @(negedge clk);
    arvalid = 0;
    total++;
    if (arready !== 1'b0 || rvalid !== 1'b1 || rdata !== 32'h77) begin
      bad++; $display("FAIL rd_lat2 arready=%b rvalid=%b rdata=%h want 0/1/77", arready, rvalid, rdata);
    end
    d0 = rdata;
    repeat (4) @(negedge clk);
    total++;
    if (rvalid !== 1'b1 || rdata !== d0) begin
      bad++; $display("FAIL rd_hold rvalid=%b rdata=%h want 1/%h", rvalid, rdata, d0);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_release rvalid=%b want=0", rvalid); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    araddr = 4'hC; arvalid = 1; rready = 1;
    repeat (2) @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hAA34_FF78) begin
      bad++; $display("FAIL collide_old rvalid=%b rdata=%h want 1/aa34ff78", rvalid, rdata);
    end
    @(negedge clk);
    rready = 0;
    check_reg("collide_new", 4'hC, 32'hDEAD_BEEF);
  endtask

  task automatic test_led();
    axi_write(4'h0, 32'h0000_01A5, 4'hF);
    @(negedge clk);
    total++;
    if (led !== 8'hA5) begin bad++; $display("FAIL led_pattern got=%h want=a5", led); end
`ifdef LED_BLINK_EN
    begin
      int n;
      logic [7:0] exp;
      axi_write(4'h8, 32'd4, 4'hF);
      axi_write(4'h4, 32'd1, 4'hF);
      n = 0;
      while (led !== 8'h00 && n < 30) begin @(negedge clk); n++; end
      total++;
      if (n >= 30) begin bad++; $display("FAIL blink_start_timeout led=%h", led); end
      for (int i = 1; i < 15; i++) begin
        @(negedge clk);
        exp = (((i / 5) % 2) == 0) ? 8'h00 : 8'hA5;
        total++;
        if (led !== exp) begin bad++; $display("FAIL blink_seq cyc=%0d got=%h want=%h", i, led, exp); end
      end
      axi_write(4'h4, 32'd0, 4'hF);
      repeat (2) @(negedge clk);
      total++;
      if (led !== 8'hA5) begin bad++; $display("FAIL blink_off got=%h want=a5", led); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 4'h4; arvalid = 1; rready = 0;
    repeat (2) @(negedge clk);
    arvalid = 0;
    total++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      bad++; $display("FAIL pre_reset bvalid=%b rvalid=%b want 1/1", bvalid, rvalid);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || arready !== 1'b0) begin
      bad++; $display("FAIL async_reset bvalid=%b rvalid=%b awready=%b arready=%b want 0",
                      bvalid, rvalid, awready, arready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) check_reg("post_reset_reg", 4'(i * 4), 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_backpressure();
    test_aw_first();
    test_read_timing();
    test_collision();
    test_led();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
